// File: rtl/mux2_arbiter.sv
// Two-requester arbitrated mux with a registered output slot.
// Fair tie-break by last grant; bursts are capped only while the other side waits.
module mux2_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             space_s, sat_s, ack0_s, ack1_s;

  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    space_s      = !out_valid_q || out_ready;
    sat_s        = (burst_cnt_q == MAX_CNT);

    case (state_q)
      IDLE: begin
        // last_grant_q==1 means requester 1 went last, so 0 wins a tie
        if (req0 && req1) begin
          state_d = last_grant_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        if (!req0) begin
          state_d = req1 ? OWN1 : IDLE;
        end else if (sat_s && req1) begin
          state_d = OWN1;
        end else begin
          ack0_s = space_s;
        end
      end
      OWN1: begin
        if (!req1) begin
          state_d = req0 ? OWN0 : IDLE;
        end else if (sat_s && req0) begin
          state_d = OWN0;
        end else begin
          ack1_s = space_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (ack0_s || ack1_s) begin
      out_valid_d = 1'b1;
      out_data_d  = ack1_s ? data1 : data0;
      burst_cnt_d = sat_s ? burst_cnt_q : burst_cnt_q + CW'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // An ack never coincides with a state change, so this cannot lose a count
    if (state_d != state_q) begin
      burst_cnt_d = '0;
      if (state_d == OWN0) begin
        last_grant_d = 1'b0;
      end else if (state_d == OWN1) begin
        last_grant_d = 1'b1;
      end else begin
        last_grant_d = last_grant_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_cnt_q  <= '0;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
    end
  end

  assign ack0      = ack0_s;
  assign ack1      = ack1_s;
  assign sel       = (state_q == OWN1);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of each requester and of the output.
REQ-002 Parameter: MAX_BURST, default 4, maximum consecutive transfers granted to one requester while the other is requesting.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0  input  1  requester 0 has a word on data0; held until ack0.
REQ-006 data0  input  WIDTH  requester 0 data; stable while req0 high.
REQ-007 ack0  output  1  word on data0 is taken this cycle.
REQ-008 req1  input  1  requester 1 has a word on data1; held until ack1.
REQ-009 data1  input  WIDTH  requester 1 data; stable while req1 high.
REQ-010 ack1  output  1  word on data1 is taken this cycle.
REQ-011 sel  output  1  current mux select: 0 = requester 0, 1 = requester 1.
REQ-012 out_valid  output  1  out_data holds a word.
REQ-013 out_data  output  WIDTH  registered mux output.
REQ-014 out_ready  input  1  downstream accepts out_data when out_valid high.

Function
REQ-015 The FSM SHALL have states IDLE, OWN0, OWN1; sel SHALL be 1 only in OWN1.
REQ-016 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> the requester not equal to last_grant; neither -> stay IDLE.
REQ-017 Define space = !out_valid || out_ready; ackX SHALL equal (state==OWNX) && reqX && space, combinational, one cycle per word.
REQ-018 On ackX the block SHALL load dataX into out_data and set out_valid at the next edge.
REQ-019 If out_valid && out_ready and no ack that cycle, out_valid SHALL clear; simultaneous accept and ack SHALL keep out_valid=1 with the new word.
REQ-020 Each ack in OWNX SHALL increment burst_cnt, saturating at MAX_BURST.
REQ-021 OWNX, reqX low: the other requester requesting -> OWN_other; otherwise -> IDLE.
REQ-022 OWNX, burst_cnt==MAX_BURST and the other requester requesting: the block SHALL switch to OWN_other with no ack to X that cycle.
REQ-023 OWNX, burst_cnt==MAX_BURST and the other requester idle: the block SHALL stay in OWNX and keep acking X.
REQ-024 Every state change SHALL reset burst_cnt to 0 and, on entry to OWNX, set last_grant to X.
REQ-025 Latency: reqX rising in IDLE at edge N -> OWNX and ackX at cycle N+1 -> out_valid at N+2, given space.
REQ-026 Backpressure: while out_valid && !out_ready, no ack SHALL assert and out_data SHALL hold.
REQ-027 The block SHALL never assert ack0 and ack1 in the same cycle.

Reset
REQ-028 While rst is high: state=IDLE, sel=0, out_valid=0, out_data=0, ack0=ack1=0, burst_cnt=0, last_grant=1 (requester 0 wins the first tie).
REQ-029 Reset mid-transfer SHALL discard any buffered word; no ack SHALL assert until the first edge after rst deasserts.

Verification
REQ-030 Single requester: req0=1, data0=8'hA5, out_ready=1 -> ack0 at cycle 1, out_valid=1, out_data=8'hA5 at cycle 2, sel=0 throughout.
REQ-031 Tie from reset: req0=req1=1 held, out_ready=1 -> 4 acks to 0, then 4 to 1, then 4 to 0; sel toggles with state; ack0 and ack1 never both high.
REQ-032 Burst without contention: req1 only for 10 words -> 10 consecutive ack1, no trip to IDLE, burst_cnt saturated at 4.
REQ-033 Backpressure: out_ready=0 with out_valid=1 for 5 cycles -> no acks, out_data unchanged; out_ready=1 with req held -> ack and replacement in the same cycle, out_valid stays 1.
REQ-034 Early release: OWN0 after 2 acks, req0 drops, req1=1 -> OWN1 next cycle, burst_cnt=0, last_grant=1.
REQ-035 Reset mid-operation: assert rst asynchronously between edges while out_valid=1 -> out_valid=0, sel=0, acks 0 immediately; after release, req0=req1=1 -> first ack to requester 0.
